// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller.
//   state_t  : controller FSM states
//   ADDR_*   : SPART core register addresses on ioaddr
//   div_of() : baud divisor (clk/(16*baud)-1 at 100 MHz) for a br_cfg code
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO  = 3'd0,
    CFG_HI  = 3'd1,
    IDLE    = 3'd2,
    RX_RD   = 3'd3,
    RX_WAIT = 3'd4,
    TX_WR   = 3'd5,
    TX_WAIT = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  function automatic logic [15:0] div_of(input logic [1:0] cfg);
    case (cfg)
      2'b00:   div_of = 16'h0515;  // 4800
      2'b01:   div_of = 16'h028A;  // 9600
      2'b10:   div_of = 16'h0145;  // 19200
      default: div_of = 16'h00A2;  // 38400
    endcase
  endfunction

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// Register-port bus between the controller (master) and the SPART core (slave).
//   iocs/iorw/ioaddr : chip select, 1=read/0=write, register address
//   bus_wdata/bus_oe : write data and databus drive enable
//   bus_rdata        : databus value returned by the core
//   rda/tbr          : core receive-data-available / transmit-buffer-ready
interface spart_bus_ctrl_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] bus_wdata;
  logic       bus_oe;
  logic [7:0] bus_rdata;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs, iorw, ioaddr, bus_wdata, bus_oe,
    input  bus_rdata, rda, tbr
  );

  modport slave (
    input  iocs, iorw, ioaddr, bus_wdata, bus_oe,
    output bus_rdata, rda, tbr
  );
endinterface

// File: rtl/spart_bus_ctrl_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters.
//   i_req : request vector      i_ptr : index searched first
//   i_en  : allow a grant       o_gnt : one-hot winner   o_sel : encoded winner
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_sel
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Walk from i_ptr upward with wrap; first requester hit wins.
  always_comb begin
    o_gnt   = '0;
    o_sel   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_sel        = w_idx;
      end
    end
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART register-port sequencer: programs the baud divisor after reset and on
// br_cfg change, drains received bytes, and shares the TX buffer between
// NUM_REQ requesters round-robin.
//   clk, rst           : clock, async active-high reset
//   i_br_cfg           : baud select
//   i_req/i_req_data   : TX requests (level) and their bytes
//   o_gnt              : one-hot 1-cycle pulse, byte accepted
//   o_rx_data/valid    : last received byte, 1-cycle update pulse
//   o_cfg_done         : divisor programmed for current br_cfg
//   o_tx_err           : sticky tbr timeout
//   bus                : register port to the SPART core
import spart_pkg::*;

module spart_bus_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int TBR_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           i_br_cfg,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [7:0]           o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_cfg_done,
  output logic                 o_tx_err,
  spart_bus_ctrl_if.master     bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TBR_TIMEOUT > 1) ? $clog2(TBR_TIMEOUT) : 1;

  state_t             r_state;
  logic [1:0]         r_cfg_q;
  logic [PW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_cfg_done;
  logic               r_tx_err;
  logic               r_iocs;
  logic               r_iorw;
  logic [1:0]         r_ioaddr;
  logic [7:0]         r_wdata;
  logic               r_oe;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PW-1:0]      w_sel;
  logic [PW-1:0]      w_next_ptr;
  logic [15:0]        w_div;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .i_en  (bus.tbr),
    .o_gnt (w_arb_gnt),
    .o_sel (w_sel)
  );

  assign w_next_ptr = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  // Low byte uses the live br_cfg (latched in the same cycle); high byte the latched copy.
  assign w_div      = div_of((r_state == CFG_LO) ? i_br_cfg : r_cfg_q);

  // Outputs are registered: each transition loads the bus values for the
  // cycle that follows it. CFG_LO/CFG_HI issue their write on the edge that
  // leaves them, so the low-byte write is visible in the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_cfg_q    <= 2'b00;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_cfg_done <= 1'b0;
      r_tx_err   <= 1'b0;
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b0;
      r_ioaddr   <= '0;
      r_wdata    <= '0;
      r_oe       <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_rx_valid <= 1'b0;
      case (r_state)
        CFG_LO: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_oe     <= 1'b1;
          r_ioaddr <= ADDR_DBL;
          r_wdata  <= w_div[7:0];
          r_cfg_q  <= i_br_cfg;
          r_state  <= CFG_HI;
        end
        CFG_HI: begin
          r_ioaddr <= ADDR_DBH;
          r_wdata  <= w_div[15:8];
          r_state  <= IDLE;
        end
        IDLE: begin
          r_iocs <= 1'b0;
          r_oe   <= 1'b0;
          if (i_br_cfg != r_cfg_q) begin
            r_cfg_done <= 1'b0;
            r_state    <= CFG_LO;
          end else begin
            r_cfg_done <= 1'b1;
            if (bus.rda) begin
              r_iocs   <= 1'b1;
              r_iorw   <= 1'b1;
              r_ioaddr <= ADDR_BUF;
              r_state  <= RX_RD;
            end else if (bus.tbr && |i_req) begin
              r_iocs   <= 1'b1;
              r_iorw   <= 1'b0;
              r_oe     <= 1'b1;
              r_ioaddr <= ADDR_BUF;
              r_wdata  <= i_req_data[{w_sel, 3'b000} +: 8];
              r_gnt    <= w_arb_gnt;
              r_ptr    <= w_next_ptr;
              r_state  <= TX_WR;
            end
          end
        end
        RX_RD: begin
          r_rx_data  <= bus.bus_rdata;
          r_rx_valid <= 1'b1;
          r_iocs     <= 1'b0;
          r_iorw     <= 1'b0;
          r_state    <= RX_WAIT;
        end
        // Hold off until the core drops rda so one byte is never read twice.
        RX_WAIT: if (!bus.rda) r_state <= IDLE;
        TX_WR: begin
          r_iocs  <= 1'b0;
          r_oe    <= 1'b0;
          r_cnt   <= '0;
          r_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!bus.tbr) begin
            r_state <= IDLE;
          end else if (r_cnt == CW'(TBR_TIMEOUT - 1)) begin
            r_tx_err <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= CFG_LO;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_cfg_done    = r_cfg_done;
  assign o_tx_err      = r_tx_err;
  assign bus.iocs      = r_iocs;
  assign bus.iorw      = r_iorw;
  assign bus.ioaddr    = r_ioaddr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_oe    = r_oe;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl. Expected bus transfers, grants and
// received bytes are queued as stimulus is applied and popped as the DUT
// produces them.
module tb_spart_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  br_cfg;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic [7:0]  rx_data;
  logic        rx_valid, cfg_done, tx_err;

  spart_bus_ctrl_if bus();

  always #5 clk = ~clk;

  spart_bus_ctrl #(.NUM_REQ(2), .TBR_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_br_cfg   (br_cfg),
    .i_req      (req),
    .i_req_data (req_data),
    .o_gnt      (gnt),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_cfg_done (cfg_done),
    .o_tx_err   (tx_err),
    .bus        (bus)
  );

  typedef struct packed {
    logic       rw;
    logic [1:0] a;
    logic [7:0] d;
  } xfer_t;

  xfer_t      exp_q[$];
  int         gnt_q[$];
  logic [7:0] rx_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
    xfer_t x;
    x = '{rw: 1'b0, a: a, d: d};
    exp_q.push_back(x);
  endtask

  task automatic exp_r();
    xfer_t x;
    x = '{rw: 1'b1, a: 2'b00, d: 8'h00};
    exp_q.push_back(x);
  endtask

  // Called once per cycle after the edge: matches whatever the DUT shows.
  task automatic monitor();
    xfer_t e, o;
    int    gi;
    logic [1:0] g;
    logic [7:0] r;
    if (bus.iocs) begin
      check("bus_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = '{rw: bus.iorw, a: bus.ioaddr, d: bus.iorw ? 8'h00 : bus.bus_wdata};
        check("bus_xfer", o, e);
        check("bus_oe", bus.bus_oe, !bus.iorw);
      end
    end
    if (gnt != 2'b00) begin
      check("gnt_expected", gnt_q.size() != 0, 1);
      check("gnt_with_write", bus.iocs && !bus.iorw, 1);
      if (gnt_q.size() != 0) begin
        gi = gnt_q.pop_front();
        g  = 2'b01 << gi;
        check("gnt", gnt, g);
      end
    end
    if (rx_valid) begin
      check("rx_expected", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) begin
        r = rx_q.pop_front();
        check("rx_data", rx_data, r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; br_cfg = 2'b01; req = 2'b00; req_data = 16'h0000;
    bus.rda = 1'b0; bus.tbr = 1'b0; bus.bus_rdata = 8'h00;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_iocs", bus.iocs, 0);
    check("rst_oe", bus.bus_oe, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_gnt", gnt, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_err", tx_err, 0);

    // Divisor after reset, br_cfg=01 -> 0x028A
    exp_w(2'b10, 8'h8A); exp_w(2'b11, 8'h02);
    rst = 1'b0;
    tick(); check("cfg1_done_c1", cfg_done, 0);
    tick(); check("cfg1_done_c2", cfg_done, 0);
    tick(); check("cfg1_done_c3", cfg_done, 1); check("cfg1_idle", bus.iocs, 0);

    // Reconfigure to 38400 -> 0x00A2
    br_cfg = 2'b11;
    exp_w(2'b10, 8'hA2); exp_w(2'b11, 8'h00);
    tick(); check("cfg2_drop", cfg_done, 0); check("cfg2_gap", bus.iocs, 0);
    ticks(2); check("cfg2_done_lo", cfg_done, 0);
    tick(); check("cfg2_done", cfg_done, 1);

    // RX: single read per rda assertion
    bus.bus_rdata = 8'h41; bus.rda = 1'b1;
    exp_r(); rx_q.push_back(8'h41);
    tick();
    tick();
    tick(); check("rx_pulse_1cyc", rx_valid, 0);
    ticks(2);
    bus.rda = 1'b0;
    ticks(2);
    bus.bus_rdata = 8'h5A; bus.rda = 1'b1;
    exp_r(); rx_q.push_back(8'h5A);
    tick();
    bus.rda = 1'b0;
    ticks(2);

    // TX: round-robin between two always-requesting sources
    req = 2'b11; req_data = 16'hAA55;
    for (int i = 0; i < 4; i++) begin
      bus.tbr = 1'b1;
      exp_w(2'b00, (i % 2 == 0) ? 8'h55 : 8'hAA);
      gnt_q.push_back(i % 2);
      tick();
      bus.tbr = 1'b0;
      ticks(3);
    end
    req = 2'b00;
    check("tx_rr_drained", gnt_q.size(), 0);

    // RX beats TX when both are pending in IDLE
    bus.rda = 1'b1; bus.bus_rdata = 8'h77; req = 2'b01; req_data = 16'h0033; bus.tbr = 1'b1;
    exp_r(); rx_q.push_back(8'h77); exp_w(2'b00, 8'h33); gnt_q.push_back(0);
    tick(); check("prio_no_gnt_rd", gnt, 0);
    bus.rda = 1'b0;
    tick(); check("prio_no_gnt_rx", gnt, 0);
    tick(); check("prio_no_gnt_wait", gnt, 0);
    tick(); check("prio_gnt_served", gnt_q.size(), 0);
    req = 2'b00; bus.tbr = 1'b0;
    ticks(3);

    // TBR timeout: tbr stuck high after a write
    req = 2'b10; req_data = 16'hC300; bus.tbr = 1'b1;
    exp_w(2'b00, 8'hC3); gnt_q.push_back(1);
    tick();
    req = 2'b00;
    tick();
    ticks(15); check("tx_err_early", tx_err, 0);
    tick(); check("tx_err_set", tx_err, 1);
    bus.rda = 1'b1; bus.bus_rdata = 8'h99;
    exp_r(); rx_q.push_back(8'h99);
    tick();
    bus.rda = 1'b0;
    ticks(3);
    check("tx_err_sticky", tx_err, 1);

    // Async reset in the middle of a read
    bus.rda = 1'b1; bus.bus_rdata = 8'h10;
    exp_r();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_iocs", bus.iocs, 0);
    check("arst_tx_err", tx_err, 0);
    check("arst_cfg_done", cfg_done, 0);
    bus.rda = 1'b0; bus.tbr = 1'b0;
    exp_w(2'b10, 8'hA2); exp_w(2'b11, 8'h00);
    #1 rst = 1'b0;
    ticks(3);
    check("arst_cfg_done_again", cfg_done, 1);

    check("bus_q_empty", exp_q.size(), 0);
    check("gnt_q_empty", gnt_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_bus_ctrl.md
Name: spart_bus_ctrl

Overview:
Bus controller that sequences the SPART core's register port (iocs/iorw/ioaddr/databus) on behalf of the rest of the design. It programs the baud divisor from br_cfg after reset and whenever br_cfg changes. It drains received bytes and shares the transmit buffer between NUM_REQ requesters with round-robin arbitration. It sits between the SPART core and the keyboard-interrupt/CPU-facing logic.

Parameters:
NUM_REQ, 2, number of transmit requesters (1..4)
TBR_TIMEOUT, 16, cycles to wait for tbr to drop after a TX write before flagging an error

Ports:
clk  in  1  100 MHz clock
rst  in  1  reset
br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
req  in  NUM_REQ  per-requester TX request, level, held until granted
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i accepted
rx_data  out  8  last received byte
rx_valid  out  1  1-cycle pulse: rx_data updated
cfg_done  out  1  high once the divisor is programmed for the current br_cfg
tx_err  out  1  sticky: TBR_TIMEOUT expired
iocs  out  1  core chip select
iorw  out  1  1=read, 0=write
ioaddr  out  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high
bus_wdata  out  8  write data to core
bus_oe  out  1  drive databus (iocs & ~iorw)
bus_rdata  in  8  databus value from core
rda  in  1  core: receive data available
tbr  in  1  core: transmit buffer ready

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All outputs 0. State CFG_LO; cfg_q=00; rr_ptr=0; timeout counter 0.
- Divisor (clk/(16*baud)-1): 00->0x0515, 01->0x028A, 10->0x0145, 11->0x00A2. Constant lookup.
- CFG_LO (1 cycle): iocs=1, iorw=0, ioaddr=10, bus_wdata=div[7:0]. Latch cfg_q=br_cfg. Next CFG_HI.
- CFG_HI (1 cycle): ioaddr=11, bus_wdata=div[15:8], computed from cfg_q. Next IDLE. cfg_done rises on entry to IDLE.
- IDLE: iocs=0. Priority, highest first:
  - (1) br_cfg!=cfg_q -> cfg_done=0, go to CFG_LO.
  - (2) rda -> RX_RD.
  - (3) tbr & |req -> TX_WR.
- RX_RD (1 cycle): iocs=1, iorw=1, ioaddr=00. Capture bus_rdata at the clock edge. rx_data and rx_valid update the following cycle. Next RX_WAIT.
- RX_WAIT: stay until rda==0, then IDLE. Prevents double read of one byte.
- TX_WR (1 cycle): sel = first requester with req set, searching from rr_ptr upward with wrap. iocs=1, iorw=0, ioaddr=00, bus_wdata=req_data[sel]. gnt[sel]=1 this cycle. rr_ptr <= sel+1 mod NUM_REQ. Next TX_WAIT, counter cleared.
- TX_WAIT: stay until tbr==0, then IDLE. If the counter reaches TBR_TIMEOUT-1 with tbr still 1, set tx_err and go to IDLE.
- Further rules:
  - gnt is never asserted outside TX_WR; at most one bit set.
  - A request dropped before grant is simply not served.
  - br_cfg changing mid-RX/TX: the current transaction completes first; reconfiguration happens from the next IDLE.
  - rda and tbr&req both high in IDLE: RX wins; TX is served on the next IDLE visit.
  - tx_err is cleared only by rst.
  - rst mid-transaction: immediate return to reset state, iocs=0 asynchronously, divisor reprogrammed.

Decomposition:
- Shared package spart_pkg: state enum; ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH); 4-entry divisor table indexed by br_cfg.
- One natural sub-module, rr_arbiter: parameterised NUM_REQ; inputs req, ptr, enable; output one-hot gnt and encoded sel.

Test Plan:
- Reset, br_cfg=01 -> cycle 1: write ioaddr=10 data 0x8A; cycle 2: ioaddr=11 data 0x02; cfg_done=1 on cycle 3.
- In IDLE, change br_cfg to 11 -> cfg_done=0, writes 0xA2 then 0x00, cfg_done=1 again.
- rda=1, bus_rdata=0x41 -> one read at ioaddr=00. rx_data=0x41 with rx_valid pulse one cycle later. No second read until rda drops and rises again.
- req=11, data 0x55/0xAA, tbr toggling low for 3 cycles after each write -> grants alternate 0,1,0,1. Core receives 55,AA,55,AA.
- rda=1 and req=01 with tbr=1 in the same cycle -> RX_RD precedes TX_WR. gnt[0] pulses only after RX_WAIT exits.
- tbr held at 1 after a write -> tx_err set after 16 cycles; controller returns to IDLE and keeps serving rda.
